// File: rtl/gene_tick_pkg.sv
// gene_tick_pkg: shared mode/state encodings and channel-select width helper for gene_tick_multi
package gene_tick_pkg;
    typedef enum logic [1:0] {MODE_OFF, MODE_PERIODIC, MODE_ONESHOT, MODE_RSVD} mode_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} ch_state_t;
    function automatic int ch_w(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/gene_tick_ch.sv
// gene_tick_ch: one channel's mode FSM, period counter, shadow divider and registered outputs
module gene_tick_ch import gene_tick_pkg::*; #(
    parameter int CNT_W = 26,
    parameter int DEFAULT_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [CNT_W-1:0] wr_div,
    input  mode_t            wr_mode,
    input  logic             start,
    output logic             tick,
    output logic             sq,
    output logic             active
);
    mode_t mode, mode_n;
    ch_state_t state, state_n;
    logic [CNT_W-1:0] count, count_n, div, div_n, shadow, shadow_n;
    logic [CNT_W:0] div_p1;
    logic term, mode_chg, go;
    // a same-cycle write is folded in before the start so the start sees the new div and mode
    always_comb begin
        mode_n = we ? wr_mode : mode;
        shadow_n = we ? wr_div : shadow;
        mode_chg = we && wr_mode != mode;
        term = state == RUN && count == div - 1'b1;
        go = start && mode_n != MODE_OFF;
        state_n = state;
        count_n = '0;
        div_n = div;
        if (go) begin
            state_n = RUN;
            div_n = shadow_n;
        end else if (mode_chg) begin
            state_n = wr_mode == MODE_PERIODIC ? RUN : IDLE;
            div_n = wr_div;
        end else if (term) begin
            state_n = mode == MODE_ONESHOT ? DONE : RUN;
            div_n = shadow_n;
        end else if (state == RUN) begin
            count_n = count + 1'b1;
        end
        div_p1 = {1'b0, div_n} + 1'b1;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode <= MODE_PERIODIC;
            state <= RUN;
            count <= '0;
            div <= CNT_W'(DEFAULT_DIV);
            shadow <= CNT_W'(DEFAULT_DIV);
            tick <= 1'b0;
            sq <= 1'b0;
            active <= 1'b1;
        end else begin
            mode <= mode_n;
            state <= state_n;
            count <= count_n;
            div <= div_n;
            shadow <= shadow_n;
            tick <= term && (go || !mode_chg);
            sq <= state_n == RUN && count_n >= div_p1[CNT_W:1];
            active <= state_n == RUN;
        end
    end
endmodule

// File: rtl/gene_tick_multi.sv
// gene_tick_multi: NB_CH programmable tick/square-wave generators with validated config writes
module gene_tick_multi import gene_tick_pkg::*; #(
    parameter int NB_CH = 4,
    parameter int CNT_W = 26,
    parameter int DEFAULT_DIV = 50_000_000,
    localparam int CH_W = ch_w(NB_CH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [1:0]       cfg_mode,
    input  logic             cfg_start,
    output logic [NB_CH-1:0] tick,
    output logic [NB_CH-1:0] sq,
    output logic [NB_CH-1:0] active,
    output logic             cfg_err
);
    logic valid;
    assign valid = 32'(cfg_ch) < NB_CH && cfg_div != '0 && cfg_mode != MODE_RSVD;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cfg_err <= 1'b0;
        else cfg_err <= cfg_we && !valid;
    end
    for (genvar i = 0; i < NB_CH; i++) begin : g_ch
        gene_tick_ch #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
            .clk(clk),
            .reset(reset),
            .we(cfg_we && valid && cfg_ch == CH_W'(i)),
            .wr_div(cfg_div),
            .wr_mode(mode_t'(cfg_mode)),
            .start(cfg_start && cfg_ch == CH_W'(i)),
            .tick(tick[i]),
            .sq(sq[i]),
            .active(active[i])
        );
    end
endmodule
